// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: multiplexed common-anode 7-segment scanner with hex decode, PWM dimming and a double-buffered frame load.
// Latency: an/a_to_g are registered one cycle after the scan state; a loaded frame first shows on digit 0 after the next frame boundary.
// Backpressure: pending stays high while a shadow frame waits for its swap; wr_en is dropped (never queued) while pending is high.
//
// Ports:
//   clk, clr                  clock, asynchronous active-high reset
//   wr_en, wr_data, wr_blank  frame load request; nibble k / blank bit k belong to digit k
//   brightness                duty level, 0 = off, all-ones = full on
//   pending                   shadow frame waiting for swap
//   frame_tick                one-cycle pulse after each frame boundary
//   a_to_g, an, dp            active-low segments (gfedcba), digit enables, decimal point
//   blink_mask                only with `define SEG7_BLINK_EN: digits forced off during the blink phase
//
// Optional feature: `define SEG7_BLINK_EN adds blink_mask and a 5-bit frame counter; blink phase = counter[4].
module seg7_scan_ctrl #(
  parameter int NUM_DIGITS  = 4,
  parameter int DIV_BITS    = 18,
  parameter int BRIGHT_BITS = 3
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic                    wr_en,
  input  logic [4*NUM_DIGITS-1:0] wr_data,
  input  logic [NUM_DIGITS-1:0]   wr_blank,
  input  logic [BRIGHT_BITS-1:0]  brightness,
`ifdef SEG7_BLINK_EN
  input  logic [NUM_DIGITS-1:0]   blink_mask,
`endif
  output logic                    pending,
  output logic                    frame_tick,
  output logic [6:0]              a_to_g,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    dp
);

  localparam int IDX_W = $clog2(NUM_DIGITS);

  logic [DIV_BITS-1:0]     clkdiv;
  logic [IDX_W-1:0]        idx;
  logic                    tick;
  logic                    boundary;
  logic [4*NUM_DIGITS-1:0] shadow_data;
  logic [4*NUM_DIGITS-1:0] active_data;
  logic [NUM_DIGITS-1:0]   shadow_blank;
  logic [NUM_DIGITS-1:0]   active_blank;
  logic [BRIGHT_BITS-1:0]  pwm;
  logic                    digit_on;
  logic                    blink_off;
  logic [3:0]              cur_nibble;
  logic [NUM_DIGITS-1:0]   an_nxt;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  assign tick       = &clkdiv;
  assign boundary   = tick && (idx == IDX_W'(NUM_DIGITS - 1));
  // Top bits of the dwell counter double as the PWM ramp, so every digit
  // gets the same duty pattern within its own dwell.
  assign pwm        = clkdiv[DIV_BITS-1 -: BRIGHT_BITS];
  assign digit_on   = (&brightness) || (pwm < brightness);
  assign cur_nibble = active_data[{idx, 2'b00} +: 4];
  assign dp         = 1'b1;

  // Scan: free-running dwell divider and digit index.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      clkdiv <= '0;
      idx    <= '0;
    end else begin
      clkdiv <= clkdiv + 1'b1;
      if (tick) begin
        idx <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
      end
    end
  end

  // Double buffer: a swap at the boundary has priority, so a write landing
  // in the same cycle as a swap is dropped because pending is still high.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      pending      <= 1'b0;
      shadow_data  <= '0;
      shadow_blank <= '0;
      active_data  <= '0;
      active_blank <= '1;
    end else if (boundary && pending) begin
      active_data  <= shadow_data;
      active_blank <= shadow_blank;
      pending      <= 1'b0;
    end else if (wr_en && !pending) begin
      shadow_data  <= wr_data;
      shadow_blank <= wr_blank;
      pending      <= 1'b1;
    end
  end

`ifdef SEG7_BLINK_EN
  logic [4:0] frame_cnt;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      frame_cnt <= '0;
    end else if (boundary) begin
      frame_cnt <= frame_cnt + 1'b1;
    end
  end

  // blink_mask is live, not part of the buffered frame.
  assign blink_off = frame_cnt[4] && blink_mask[idx];
`else
  assign blink_off = 1'b0;
`endif

  // Only the scanned digit can ever be driven low.
  always_comb begin
    an_nxt = '1;
    if (digit_on && !active_blank[idx] && !blink_off) begin
      an_nxt[idx] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      an         <= '1;
      a_to_g     <= 7'b1111111;
      frame_tick <= 1'b0;
    end else begin
      an         <= an_nxt;
      a_to_g     <= hex_to_seg(cur_nibble);
      frame_tick <= boundary;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: directed plus random stimulus for seg7_scan_ctrl against a cycle-count reference model.
// Latency: expected outputs are those of the scan position reached one edge earlier.
// Backpressure: model drops writes while its own pending flag is set.
`timescale 1ns/1ps
module tb_seg7_scan_ctrl;

  localparam int ND = 4;
  localparam int DB = 4;
  localparam int BB = 3;

  logic        clk = 1'b0;
  logic        clr;
  logic        wr_en;
  logic [15:0] wr_data;
  logic [3:0]  wr_blank;
  logic [2:0]  brightness;
  logic        pending;
  logic        frame_tick;
  logic [6:0]  a_to_g;
  logic [3:0]  an;
  logic        dp;
`ifdef SEG7_BLINK_EN
  logic [3:0]  blink_mask = '0;
`endif

  always #5 clk = ~clk;

  seg7_scan_ctrl #(
    .NUM_DIGITS (ND),
    .DIV_BITS   (DB),
    .BRIGHT_BITS(BB)
  ) dut (
    .clk       (clk),
    .clr       (clr),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .wr_blank  (wr_blank),
    .brightness(brightness),
`ifdef SEG7_BLINK_EN
    .blink_mask(blink_mask),
`endif
    .pending   (pending),
    .frame_tick(frame_tick),
    .a_to_g    (a_to_g),
    .an        (an),
    .dp        (dp)
  );

  logic [6:0] seg_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  // Model state: cyc = clock edges since reset release.
  int          cyc;
  logic        m_pending;
  logic [15:0] m_sh_d, m_act_d;
  logic [3:0]  m_sh_b, m_act_b;

  task automatic model_reset();
    cyc       = 0;
    m_pending = 1'b0;
    m_sh_d    = '0;
    m_sh_b    = '0;
    m_act_d   = '0;
    m_act_b   = 4'hF;
  endtask

  // One clock edge: predict from the scan position (derived from cyc), apply
  // the frame rules, then compare #1 after the edge.
  task automatic step();
    int         cd, ix;
    bit         bnd, on;
    logic [3:0] e_an, nib;
    logic [6:0] e_seg;
    cd   = cyc % 16;
    ix   = (cyc / 16) % 4;
    bnd  = (cyc % 64) == 63;
    on   = (brightness == 3'd7) || ((cd / 2) < int'(brightness));
    e_an = 4'hF;
    if (on && !m_act_b[ix]) e_an[ix] = 1'b0;
    nib   = m_act_d[4*ix +: 4];
    e_seg = seg_tab[nib];
    if (bnd && m_pending) begin
      m_act_d   = m_sh_d;
      m_act_b   = m_sh_b;
      m_pending = 1'b0;
    end else if (wr_en && !m_pending) begin
      m_sh_d    = wr_data;
      m_sh_b    = wr_blank;
      m_pending = 1'b1;
    end
    cyc++;
    @(posedge clk);
    #1;
    chk("an", an, e_an);
    chk("a_to_g", a_to_g, e_seg);
    chk("pending", pending, m_pending);
    chk("frame_tick", frame_tick, bnd);
    chk("dp", dp, 1);
  endtask

  task automatic run_until(input int target);
    while (cyc < target) step();
  endtask

  task automatic do_reset();
    clr   = 1'b1;
    wr_en = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_an", an, 4'hF);
    chk("rst_seg", a_to_g, 7'h7F);
    chk("rst_pending", pending, 0);
    chk("rst_dp", dp, 1);
    chk("rst_frame_tick", frame_tick, 0);
    clr = 1'b0;
    model_reset();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cnt0, cnt1, cnt2, cnt_on;
    clr        = 1'b1;
    wr_en      = 1'b0;
    wr_data    = '0;
    wr_blank   = '0;
    brightness = 3'd7;
    model_reset();

    do_reset();
    repeat (3) step();
    chk("release_an", an, 4'hF);

    // Load, then a write while pending must be dropped.
    wr_data  = 16'h1A2F;
    wr_blank = 4'h0;
    wr_en    = 1'b1;
    step();
    wr_en = 1'b0;
    chk("load_pending", pending, 1);
    wr_data = 16'h5555;
    wr_en   = 1'b1;
    step();
    wr_en = 1'b0;

    run_until(65);
    chk("swap_pending", pending, 0);
    chk("swap_d0_an", an, 4'b1110);
    cnt0 = 0;
    repeat (16) begin
      if (a_to_g == 7'b0001110) cnt0++;
      step();
    end
    chk("d0_dwell", cnt0, 16);
    run_until(113);
    chk("d3_seg", a_to_g, 7'b1111001);
    chk("d3_an", an, 4'b0111);

    // Write in the boundary cycle with nothing pending: captured, shown one frame later.
    run_until(127);
    wr_data = 16'hBEE3;
    wr_en   = 1'b1;
    step();
    wr_en = 1'b0;
    chk("coll_pending", pending, 1);
    run_until(129);
    chk("coll_old_frame", a_to_g, 7'b0001110);
    run_until(193);
    chk("coll_new_frame", a_to_g, 7'b0110000);

    // Blanking and brightness.
    wr_data  = 16'h4567;
    wr_blank = 4'b0100;
    wr_en    = 1'b1;
    step();
    wr_en      = 1'b0;
    wr_blank   = 4'h0;
    brightness = 3'd3;
    run_until(257);
    cnt0 = 0; cnt1 = 0; cnt2 = 0;
    repeat (64) begin
      if (!an[0]) cnt0++;
      if (!an[1]) cnt1++;
      if (!an[2]) cnt2++;
      step();
    end
    chk("bright3_d0", cnt0, 6);
    chk("bright3_d1", cnt1, 6);
    chk("blank_d2", cnt2, 0);
    brightness = 3'd0;
    step();
    cnt_on = 0;
    repeat (64) begin
      if (an != 4'hF) cnt_on++;
      step();
    end
    chk("bright0_off", cnt_on, 0);

    // Random traffic.
    repeat (1500) begin
      wr_en    = ($urandom_range(0, 3) == 0);
      wr_data  = 16'($urandom);
      wr_blank = 4'($urandom);
      if ($urandom_range(0, 63) == 0) brightness = 3'($urandom);
      step();
    end

    // Async reset mid-dwell with a frame pending.
    brightness = 3'd7;
    wr_blank   = 4'h0;
    wr_en      = 1'b1;
    for (int i = 0; i < 200 && !m_pending; i++) step();
    wr_en = 1'b0;
    chk("pre_rst_pending", pending, 1);
    repeat (5) step();
    #2;
    clr = 1'b1;
    #1;
    chk("arst_an", an, 4'hF);
    chk("arst_pending", pending, 0);
    chk("arst_seg", a_to_g, 7'h7F);
    chk("arst_frame_tick", frame_tick, 0);
    repeat (3) @(posedge clk);
    #1;
    clr = 1'b0;
    model_reset();
    repeat (80) step();
    chk("post_arst_an", an, 4'hF);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
